// File: rtl/fp_std_pkg.sv
// Shared types and constants for the fp24 add/sub front stage.
// fp24 layout: 1 sign, 8 exponent (bias 127), 15 stored fraction bits.
package fp_std_pkg;

  localparam int FP_EW   = 8;
  localparam int FP_MW   = 15;
  localparam int FP_BIAS = 127;

  typedef struct packed {
    logic             sign;
    logic [FP_EW-1:0] exp;
    logic [FP_MW-1:0] frac;
  } fp24_t;

  typedef enum logic [1:0] {
    FP_ADD = 2'b00,
    FP_SUB = 2'b01
  } fp_op_e;

  typedef struct packed {
    logic             sign;
    logic [FP_EW-1:0] exp;
    logic [FP_MW+1:0] mant;
    logic             zero;
    logic             sticky;
  } raw_result_t;

  // No denormals: a zero exponent means the operand is zero.
  function automatic logic [FP_MW:0] unpack_mant(fp24_t x);
    return (x.exp == '0) ? '0 : {1'b1, x.frac};
  endfunction

endpackage

// File: rtl/fp_std_0_if.sv
// Operand/result bundle between the fp24 front stage (slave) and its
// neighbours (master drives operands and out_ready, observes results).
interface fp_std_0_if;
  import fp_std_pkg::*;

  // Valid/ready: a beat transfers on a cycle where valid & ready are both 1;
  // once valid is raised the payload is held until it transfers.
  logic                  in_valid;
  logic                  in_ready;
  logic [23:0]           in_a;
  logic [23:0]           in_b;
  logic [3:0]            in_opcode;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sign;
  logic [FP_EW-1:0]      out_exp;
  logic [FP_MW+1:0]      out_mant;
  logic                  out_zero;
  logic [3:0]            out_opcode;
  logic                  out_sticky;

  modport master (
    output in_valid, in_a, in_b, in_opcode, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero,
           out_opcode, out_sticky
  );

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero,
           out_opcode, out_sticky
  );

endinterface

// File: rtl/fp_align_shifter.sv
// Right shifter for the smaller mantissa; amounts of 16 or more flush to 0.
// Sticky (OR of dropped bits) is only produced when FP_ALIGN_STICKY_EN is defined.
module fp_align_shifter
  import fp_std_pkg::*;
(
  input  logic [FP_MW:0]   mant_i,
  input  logic [FP_EW-1:0] amt_i,
  output logic [FP_MW:0]   mant_o,
  output logic             sticky_o
);

  logic sat;

  always_comb begin
    sat    = (amt_i[FP_EW-1:4] != '0);
    mant_o = sat ? '0 : (mant_i >> amt_i[3:0]);
`ifdef FP_ALIGN_STICKY_EN
    sticky_o = sat ? (|mant_i)
                   : (|(mant_i & ~({(FP_MW+1){1'b1}} << amt_i[3:0])));
`else
    sticky_o = 1'b0;
`endif
  end

endmodule

// File: rtl/fp_std_0.sv
// fp24 add/sub front stage: swap + exponent diff (stage 1), align + add/sub
// (stage 2). Optional sticky/borrow path enabled by FP_ALIGN_STICKY_EN.
module fp_std_0
  import fp_std_pkg::*;
#(
  parameter int EW = FP_EW,
  parameter int MW = FP_MW
) (
  input logic       clk,
  input logic       rst_n,
  fp_std_0_if.slave bus
);

  fp24_t         a, b;
  logic [MW:0]   mant_a, mant_b;
  logic [1:0]    op_lo;
  logic          sub_op, sign_b_eff, a_is_l;
  logic          adv1, adv2;

  logic          v1_q;
  logic [MW:0]   mant_l_q, mant_s_q, mant_l_d, mant_s_d;
  logic [EW-1:0] diff_q, exp_l_q, diff_d, exp_l_d;
  logic          sign_l_q, eff_sub_q, both_zero_q, zero_sign_q;
  logic          sign_l_d, eff_sub_d, both_zero_d, zero_sign_d;
  logic [3:0]    opcode_q;

  logic          v2_q;
  logic [MW:0]   s_al;
  logic          sticky, borrow;
  logic [MW+1:0] sum;
  raw_result_t   res_q, res_d;
  logic [3:0]    out_opcode_q;

  assign adv2         = !v2_q || bus.out_ready;
  assign adv1         = !v1_q || adv2;
  assign bus.in_ready = adv1;

  always_comb begin
    a           = bus.in_a;
    b           = bus.in_b;
    mant_a      = unpack_mant(a);
    mant_b      = unpack_mant(b);
    op_lo       = bus.in_opcode[1:0];
    sub_op      = (op_lo == FP_SUB);
    sign_b_eff  = b.sign ^ sub_op;
    // Tie on magnitude keeps A as the larger operand.
    a_is_l      = {a.exp, mant_a} >= {b.exp, mant_b};
    mant_l_d    = a_is_l ? mant_a : mant_b;
    mant_s_d    = a_is_l ? mant_b : mant_a;
    exp_l_d     = a_is_l ? a.exp : b.exp;
    diff_d      = a_is_l ? (a.exp - b.exp) : (b.exp - a.exp);
    sign_l_d    = a_is_l ? a.sign : sign_b_eff;
    eff_sub_d   = a.sign ^ sign_b_eff;
    both_zero_d = (a.exp == '0) && (b.exp == '0);
    zero_sign_d = a.sign & sign_b_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      mant_l_q    <= '0;
      mant_s_q    <= '0;
      diff_q      <= '0;
      exp_l_q     <= '0;
      sign_l_q    <= 1'b0;
      eff_sub_q   <= 1'b0;
      both_zero_q <= 1'b0;
      zero_sign_q <= 1'b0;
      opcode_q    <= '0;
    end else begin
      if (adv1) v1_q <= bus.in_valid;
      if (adv1 && bus.in_valid) begin
        mant_l_q    <= mant_l_d;
        mant_s_q    <= mant_s_d;
        diff_q      <= diff_d;
        exp_l_q     <= exp_l_d;
        sign_l_q    <= sign_l_d;
        eff_sub_q   <= eff_sub_d;
        both_zero_q <= both_zero_d;
        zero_sign_q <= zero_sign_d;
        opcode_q    <= bus.in_opcode;
      end
    end
  end

  fp_align_shifter u_shift (
    .mant_i   (mant_s_q),
    .amt_i    (diff_q),
    .mant_o   (s_al),
    .sticky_o (sticky)
  );

  always_comb begin
    // Dropped bits of S act as a borrow on the subtract path.
    borrow = eff_sub_q & sticky;
    if (eff_sub_q) sum = {1'b0, mant_l_q} - {1'b0, s_al} - {{(MW+1){1'b0}}, borrow};
    else           sum = {1'b0, mant_l_q} + {1'b0, s_al};
    res_d = '0;
    if (opcode_q[1]) begin
      res_d.zero = 1'b1;
    end else if (both_zero_q) begin
      res_d.zero = 1'b1;
      res_d.sign = zero_sign_q;
    end else begin
      res_d.mant   = sum;
      res_d.exp    = exp_l_q;
      res_d.zero   = (sum == '0);
      res_d.sign   = (sum == '0) ? 1'b0 : sign_l_q;
      res_d.sticky = sticky;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q         <= 1'b0;
      res_q        <= '0;
      out_opcode_q <= '0;
    end else begin
      if (adv2) v2_q <= v1_q;
      if (adv2 && v1_q) begin
        res_q        <= res_d;
        out_opcode_q <= opcode_q;
      end
    end
  end

  assign bus.out_valid  = v2_q;
  assign bus.out_sign   = res_q.sign;
  assign bus.out_exp    = res_q.exp;
  assign bus.out_mant   = res_q.mant;
  assign bus.out_zero   = res_q.zero;
  assign bus.out_sticky = res_q.sticky;
  assign bus.out_opcode = out_opcode_q;

endmodule

// File: doc/fp_std_0.md
Name: fp_std_0

Overview:
- Front (align/add) stage of the fp24 add/sub datapath: unpacks two fp24 operands (1 sign, 8 exp, 15 mantissa, hidden 1, bias 127).
- Compares magnitudes, swaps, right-aligns the smaller mantissa and adds or subtracts.
- Emits an unnormalised raw result (sign, larger exponent, 17-bit mantissa) to the normalise/round stage directly downstream.
- Two-stage pipeline with valid/ready handshake; stalls under downstream backpressure.

Parameters:
- EW, 8, exponent width
- MW, 15, stored mantissa width (hidden bit added internally)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept operands
- in_a  in  24  operand A, fp24
- in_b  in  24  operand B, fp24
- in_opcode  in  4  [1:0]=00 add, 01 sub (A-B), 1x invalid; [3:2] carried through
- out_valid  out  1  raw result valid
- out_ready  in  1  downstream accepts
- out_sign  out  1  result sign
- out_exp  out  8  larger operand exponent (unadjusted)
- out_mant  out  17  [16]=carry, [15]=hidden-bit position, [14:0] fraction; unnormalised
- out_zero  out  1  exact zero result
- out_opcode  out  4  opcode passthrough (downstream selects add/sub path)
- out_sticky  out  1  OR of bits shifted out during alignment (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): both stage valids 0; out_valid=0, in_ready=1; all out_* data registers 0.
- Operand decode: exp==0 means operand is zero (no denormals), mantissa forced to 0, hidden bit 0. Otherwise mantissa is {1,frac} (16 bits).
- Effective subtract: eff_sub = opcode[0] ^ sign_a ^ sign_b; B sign is flipped when opcode[0]=1.
- Stage 1 (registered at the end of cycle 1):
  - Magnitude compare on {exp,frac}; larger operand becomes L, the other S; on a tie A is L.
  - Register L mantissa, S mantissa, diff = exp_L - exp_S (8-bit, unsigned), exp_L, sign_L, eff_sub, opcode.
- Stage 2 (registered at the end of cycle 2):
  - S mantissa shifted right by diff; diff>=16 yields 0.
  - Add: out_mant = L + S_aligned (17-bit).
  - Sub: out_mant = L - S_aligned; never negative because of the swap.
  - out_sign = sign_L; out_exp = exp_L.
  - out_zero=1 when out_mant==0. Exact cancellation forces out_sign=0.
  - Both operands zero: out_zero=1, out_exp=0, out_sign = sign_a & sign_b for add.
- Invalid opcode (opcode[1:0]=1x): the transaction still flows. out_mant=0, out_exp=0, out_sign=0, out_zero=1, opcode passed through.
- Latency: 2 cycles from an accepted input to out_valid, no stall. Throughput 1 per cycle.
- Handshake:
  - Input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
  - Stage 2 advances when !v2 | out_ready.
  - Stage 1 advances when !v1 | stage-2 advance.
  - in_ready = stage-1 advance, combinational from out_ready. No skid buffer.
  - While out_valid & !out_ready: all out_* hold stable and in_ready drops once both stages are full.
  - Simultaneous accept and consume in one cycle: full throughput, no bubble.
- in_* is sampled only on accept; changes while in_ready=0 are ignored.
- Reset mid-operation discards in-flight data; no partial result is emitted.

Optional Feature:
- FP_ALIGN_STICKY_EN defined:
  - Alignment shifter computes sticky = OR of all bits shifted out of S (whole S mantissa when diff>=16).
  - Sticky is registered alongside the result on out_sticky.
  - Sub with sticky=1 subtracts one extra LSB (borrow from truncated bits).
- Undefined: out_sticky is tied 0 and no extra borrow is applied (truncating behaviour).

Decomposition:
- Package fp_std_pkg:
  - fp24_t packed struct {sign, exp[7:0], frac[14:0]}
  - FP_EW, FP_MW, FP_BIAS=127 constants
  - fp_op_e enum (FP_ADD=2'b00, FP_SUB=2'b01)
  - raw_result_t struct (sign, exp, mant[16:0], zero, sticky)
- Sub-module fp_align_shifter: combinational 16-bit right shifter by 8-bit amount, saturating at >=16, with sticky output. Instantiated in stage 2.

Test Plan:
- 0x3F8000 + 0x3F8000 (1.0+1.0), opcode 0, out_ready=1 -> after 2 cycles out_exp=0x7F, out_mant=0x10000, out_sign=0, out_zero=0.
- 0x3FC000 - 0x3F8000 (1.5-1.0) -> out_exp=0x7F, out_mant=0x04000, out_sign=0.
- 0x3F8000 - 0x3FC000 (1.0-1.5) -> swap: out_sign=1, out_mant=0x04000.
- 0x3F8000 - 0x3F8000 -> out_zero=1, out_mant=0, out_sign=0.
- 0x3F8000 + 0x358000 (exp diff 20) -> out_mant=0x08000. With FP_ALIGN_STICKY_EN defined, out_sticky=1.
- Stream 4 back-to-back adds, hold out_ready=0 for 3 cycles after the first out_valid:
  - outputs hold stable and in_ready=0 once both stages are full;
  - on release, all 4 results appear in order with no loss or duplication;
  - asserting rst_n=0 mid-stream clears out_valid within the same cycle.
